// File: rtl/internal_bus_arbiter.sv
// Round-robin arbiter granting N_CH internal requesters onto one shared memory port,
// with a per-transaction timeout and halt gating of new grants.
module internal_bus_arbiter #(
  parameter int N_CH    = 4,
  parameter int OWN_W   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req_rd,
  input  logic [N_CH-1:0]          req_wr,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*DATA_W-1:0]   req_wdata,
  input  logic                     halt_q,
  output logic [N_CH-1:0]          gnt,
  output logic [OWN_W-1:0]         owner,
  output logic [N_CH-1:0]          rsp_done,
  output logic [N_CH-1:0]          rsp_err,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     bus_busy,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_W-1:0]        data_out,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     read_q,
  output logic                     write_q,
  input  logic                     read_dn,
  input  logic                     write_dn
);

  // IDLE: arbitrate | ACCESS: strobe held until ack or timeout | DONE: response pulse, pointer update
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              state_q;
  logic [OWN_W-1:0]    ptr_q;
  logic [OWN_W-1:0]    owner_q;
  logic [N_CH-1:0]     gnt_q;
  logic [N_CH-1:0]     done_q;
  logic [N_CH-1:0]     err_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rd_stb_q;
  logic                wr_stb_q;
  logic [TO_W-1:0]     cnt_q;

  logic [N_CH-1:0]     req_any;
  logic                found;
  logic [OWN_W-1:0]    sel;
  logic [OWN_W-1:0]    idx;
  logic [N_CH-1:0]     sel_oh;
  logic                ack;

  assign req_any = req_rd | req_wr;
  assign ack     = wr_stb_q ? write_dn : read_dn;

  // First requester strictly after the last owner, wrapping around.
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    idx    = '0;
    sel_oh = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = OWN_W'((int'(ptr_q) + i) % N_CH);
      if (!found && req_any[idx]) begin
        found       = 1'b1;
        sel         = idx;
        sel_oh[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= OWN_W'(N_CH - 1);
      owner_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (!halt_q && found) begin
            owner_q  <= sel;
            gnt_q    <= sel_oh;
            addr_q   <= req_addr[int'(sel)*ADDR_W +: ADDR_W];
            wdata_q  <= req_wdata[int'(sel)*DATA_W +: DATA_W];
            wr_stb_q <= req_wr[sel];
            rd_stb_q <= !req_wr[sel];
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (ack) begin
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            gnt_q    <= '0;
            done_q   <= gnt_q;
            if (rd_stb_q) rdata_q <= data_in;
            state_q  <= S_DONE;
          end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            gnt_q    <= '0;
            err_q    <= gnt_q;
            rdata_q  <= '0;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          ptr_q   <= owner_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign rsp_done  = done_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;
  assign bus_busy  = busy_q;
  assign addr      = addr_q;
  assign data_out  = wdata_q;
  assign read_q    = rd_stb_q;
  assign write_q   = wr_stb_q;

endmodule

// File: tb/tb_internal_bus_arbiter.sv
// Directed bench for internal_bus_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_internal_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_rd, req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            halt_q;
  logic [N-1:0]    gnt, rsp_done, rsp_err;
  logic [1:0]      owner;
  logic [DW-1:0]   rsp_rdata, data_out, data_in;
  logic [AW-1:0]   addr;
  logic            bus_busy, read_q, write_q, read_dn, write_dn;
  logic            rd_man, wr_man, auto_ack;

  assign read_dn  = rd_man | (auto_ack & read_q);
  assign write_dn = wr_man | (auto_ack & write_q);

  internal_bus_arbiter #(.N_CH(N), .OWN_W(2), .ADDR_W(AW), .DATA_W(DW), .TO_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .halt_q(halt_q), .gnt(gnt), .owner(owner), .rsp_done(rsp_done),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .bus_busy(bus_busy), .addr(addr),
    .data_out(data_out), .data_in(data_in), .read_q(read_q), .write_q(write_q),
    .read_dn(read_dn), .write_dn(write_dn));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: one outstanding transaction record, rotated-priority pick by distance.
  logic          m_valid = 1'b0;
  logic [N-1:0]  m_gnt, m_done, m_err;
  logic [1:0]    m_owner, m_ptr;
  logic [DW-1:0] m_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic          m_busy, m_rd, m_wr;
  bit            t_act, t_end;
  int            t_wait;

  task automatic model_step();
    int best, bd, d;
    if (rst) begin
      m_valid = 1'b1; m_gnt = '0; m_done = '0; m_err = '0; m_owner = '0; m_ptr = 2'(N - 1);
      m_rdata = '0; m_wdata = '0; m_addr = '0; m_busy = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
      t_act = 1'b0; t_end = 1'b0; t_wait = 0;
    end else begin
      m_done = '0;
      m_err  = '0;
      if (t_end) begin
        t_end = 1'b0; t_act = 1'b0; m_busy = 1'b0; m_ptr = m_owner;
      end else if (t_act) begin
        if ((m_wr && write_dn) || (m_rd && read_dn)) begin
          m_done[m_owner] = 1'b1;
          if (m_rd) m_rdata = data_in;
          m_rd = 1'b0; m_wr = 1'b0; m_gnt = '0; t_end = 1'b1;
        end else begin
          t_wait++;
          if (t_wait == TO) begin
            m_err[m_owner] = 1'b1;
            m_rdata = '0; m_rd = 1'b0; m_wr = 1'b0; m_gnt = '0; t_end = 1'b1;
          end
        end
      end else if (!halt_q && (req_rd | req_wr) != '0) begin
        best = -1; bd = N;
        for (int c = 0; c < N; c++) begin
          d = (c - int'(m_ptr) - 1 + 2 * N) % N;
          if ((req_rd[c] || req_wr[c]) && d < bd) begin best = c; bd = d; end
        end
        m_owner = 2'(best);
        m_gnt = '0; m_gnt[best] = 1'b1;
        m_wr = req_wr[best]; m_rd = !req_wr[best];
        m_addr = req_addr[best*AW +: AW]; m_wdata = req_wdata[best*DW +: DW];
        m_busy = 1'b1; t_act = 1'b1; t_wait = 0;
      end
    end
  endtask

  task automatic compare_step();
    if (m_valid) begin
      chk("gnt", 64'(gnt), 64'(m_gnt));
      chk("owner", 64'(owner), 64'(m_owner));
      chk("rsp_done", 64'(rsp_done), 64'(m_done));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
      chk("bus_busy", 64'(bus_busy), 64'(m_busy));
      chk("read_q", 64'(read_q), 64'(m_rd));
      chk("write_q", 64'(write_q), 64'(m_wr));
      if (m_rd || m_wr) begin
        chk("addr", 64'(addr), 64'(m_addr));
        chk("data_out", 64'(data_out), 64'(m_wdata));
      end
      if ((rsp_done & rsp_err) != '0) chk("done_and_err", 64'(rsp_done & rsp_err), 64'd0);
    end
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) compare_step();

  task automatic run_wr1(input bit ack_exp, output int hi, output logic [N-1:0] errs,
                         output logic [N-1:0] dns);
    hi = 0; errs = '0; dns = '0;
    @(negedge clk);
    req_wr = 4'b0010;
    req_wdata[1*DW +: DW] = ack_exp ? 32'hA5A5_0002 : 32'hA5A5_0001;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) req_wr = '0;
      if (write_q) hi++;
      errs = errs | rsp_err;
      dns  = dns | rsp_done;
      wr_man = ack_exp && (c == 4);
    end
  endtask

  logic [N-1:0] g_seen[$];
  int           g_cyc[$];
  logic [N-1:0] exp_g[5];
  logic [N-1:0] prev_g, errs, dns;
  int           hi;

  initial begin
    rst = 1'b1; req_rd = '0; req_wr = '0; halt_q = 1'b0; data_in = '0;
    rd_man = 1'b0; wr_man = 1'b0; auto_ack = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = 32'h1000 + 32'(i);
      req_wdata[i*DW +: DW] = 32'h5000 + 32'(i);
    end
    req_addr[2*AW +: AW] = 32'h100;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_busy", 64'(bus_busy), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;

    // single read on ch2, ack two cycles after strobe
    @(negedge clk); req_rd = 4'b0100;
    @(negedge clk);
    chk("rd_gnt", 64'(gnt), 64'h4);
    chk("rd_strobe", 64'(read_q), 64'd1);
    chk("rd_addr", 64'(addr), 64'h100);
    req_rd = '0;
    @(negedge clk); rd_man = 1'b1; data_in = 32'hDEADBEEF;
    @(negedge clk); rd_man = 1'b0;
    chk("rd_done", 64'(rsp_done), 64'h4);
    chk("rd_data", 64'(rsp_rdata), 64'hDEADBEEF);
    @(negedge clk);
    chk("rd_idle", 64'(bus_busy), 64'd0);

    // round robin, all channels, zero-wait ack
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; auto_ack = 1'b1; data_in = 32'h1234_5678; req_rd = 4'b1111;
    prev_g = '0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (gnt != '0 && prev_g == '0) begin g_seen.push_back(gnt); g_cyc.push_back(c); end
      prev_g = gnt;
    end
    req_rd = '0;
    repeat (4) @(negedge clk);
    auto_ack = 1'b0;
    chk("rr_count_ge5", 64'(g_seen.size() >= 5), 64'd1);
    for (int i = 0; i < 5 && i < g_seen.size(); i++) begin
      chk("rr_order", 64'(g_seen[i]), 64'(exp_g[i]));
      if (i > 0) chk("rr_spacing", 64'(g_cyc[i] - g_cyc[i-1]), 64'd3);
    end

    // timeout, then the same with an ack on the expiry edge
    run_wr1(1'b0, hi, errs, dns);
    chk("to_strobe_cycles", 64'(hi), 64'd4);
    chk("to_err", 64'(errs), 64'h2);
    chk("to_no_done", 64'(dns), 64'd0);
    chk("to_rdata", 64'(rsp_rdata), 64'd0);
    run_wr1(1'b1, hi, errs, dns);
    wr_man = 1'b0;
    chk("exp_ack_done", 64'(dns), 64'h2);
    chk("exp_ack_no_err", 64'(errs), 64'd0);

    // halt gating
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; halt_q = 1'b1; req_rd = 4'b1001;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("halt_no_gnt", 64'(gnt), 64'd0);
    end
    halt_q = 1'b0;
    @(negedge clk);
    chk("halt_release_gnt", 64'(gnt), 64'h1);
    halt_q = 1'b1;
    @(negedge clk); rd_man = 1'b1; data_in = 32'hCAFE_0001;
    @(negedge clk); rd_man = 1'b0;
    chk("halt_mid_done", 64'(rsp_done), 64'h1);
    @(negedge clk);
    chk("halt_hold_gnt", 64'(gnt), 64'd0);
    req_rd = '0; halt_q = 1'b0;
    @(negedge clk);

    // rd+wr on ch1: write wins, wrong ack ignored
    @(negedge clk); req_rd = 4'b0010; req_wr = 4'b0010;
    @(negedge clk);
    chk("rw_write_q", 64'(write_q), 64'd1);
    chk("rw_read_q", 64'(read_q), 64'd0);
    req_rd = '0; req_wr = '0;
    @(negedge clk); rd_man = 1'b1;
    @(negedge clk); rd_man = 1'b0;
    chk("rw_wrong_ack_strobe", 64'(write_q), 64'd1);
    chk("rw_wrong_ack_done", 64'(rsp_done), 64'd0);
    wr_man = 1'b1;
    @(negedge clk); wr_man = 1'b0;
    chk("rw_done", 64'(rsp_done), 64'h2);
    chk("rw_drop", 64'(write_q), 64'd0);
    repeat (2) @(negedge clk);

    // reset in the middle of a read
    @(negedge clk); req_rd = 4'b0001;
    @(negedge clk);
    chk("mr_read_q", 64'(read_q), 64'd1);
    rst = 1'b1; req_rd = '0;
    @(negedge clk);
    chk("mr_gnt", 64'(gnt), 64'd0);
    chk("mr_read_q0", 64'(read_q), 64'd0);
    chk("mr_busy", 64'(bus_busy), 64'd0);
    chk("mr_owner", 64'(owner), 64'd0);
    chk("mr_addr", 64'(addr), 64'd0);
    rst = 1'b0; rd_man = 1'b1;
    @(negedge clk); rd_man = 1'b0;
    chk("mr_late_ack", 64'(rsp_done), 64'd0);
    @(negedge clk);
    chk("mr_late_ack2", 64'(rsp_done), 64'd0);
    req_rd = 4'b0101;
    @(negedge clk);
    chk("mr_first_gnt", 64'(gnt), 64'h1);
    req_rd = '0; auto_ack = 1'b1;
    repeat (4) @(negedge clk);
    auto_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
